instr_sequencer: RTL and testbench

- Multi-cycle control front end that drives the ALU/register-file datapath.
- Fetches instructions from instruction memory over a req/valid handshake, holds them in an instruction register, and decodes them into datapath controls (RegWrite, ALUsrc, ALUctrl, rs1/rs2/rd, ImmOp).
- Consumes the datapath's EQ flag to resolve branches and updates the PC.
- Supported subset: addi, add, sub, bne. All other encodings are faults.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/instr_sequencer_imm_gen.sv | 24 ++
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 tb/tb_instr_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
//============================================================================
// Module      : seq_pkg
// Description : Shared types and constants for the instruction sequencer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001
    } alu_op_e;

    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP     = 7'b0110011;
    localparam logic [6:0]  BRANCH = 7'b1100011;
    localparam logic [31:0] NOP    = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_imm_gen.sv
//============================================================================
// Module      : imm_gen
// Description : Combinational I-type and B-type immediate extraction.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module imm_gen (
    input  logic [31:0] ir_i,
    output logic [31:0] imm_i_o,
    output logic [31:0] imm_b_o
);

    logic w_unused_bits;

    assign imm_i_o = {{20{ir_i[31]}}, ir_i[31:20]};
    assign imm_b_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};

    // Register-address and opcode fields carry no immediate bits.
    assign w_unused_bits = ^{ir_i[19:12], ir_i[6:0]};

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
//============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle fetch/decode/execute control front end for the
//               ALU/register-file datapath (addi, add, sub, bne).
//               Optional macro SEQ_TIMEOUT_EN adds a fetch timeout.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module instr_sequencer
    import seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        EQ,
    output logic        RegWrite,
    output logic        ALUsrc,
    output logic [2:0]  ALUctrl,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] ImmOp,
    output logic [31:0] pc,
    output logic        fault,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        fault_q, fault_d;

    logic [31:0] w_imm_i, w_imm_b, w_br_target;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic        w_is_addi, w_is_add, w_is_sub, w_is_bne, w_legal, w_writes, w_tmo;

    imm_gen u_imm_gen (
        .ir_i    (ir_q),
        .imm_i_o (w_imm_i),
        .imm_b_o (w_imm_b)
    );

    assign w_opcode = ir_q[6:0];
    assign w_funct3 = ir_q[14:12];
    assign w_funct7 = ir_q[31:25];

    assign w_is_addi = (w_opcode == OP_IMM) && (w_funct3 == 3'b000);
    assign w_is_add  = (w_opcode == OP) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
    assign w_is_sub  = (w_opcode == OP) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0100000);
    assign w_is_bne  = (w_opcode == BRANCH) && (w_funct3 == 3'b001);
    assign w_legal   = w_is_addi || w_is_add || w_is_sub || w_is_bne;
    assign w_writes  = w_is_addi || w_is_add || w_is_sub;

    assign w_br_target = pc_q + w_imm_b;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_q, tmo_d;

    assign tmo_d = (state_q == FETCH && !imem_valid) ? tmo_q + CW'(1) : '0;
    assign w_tmo = (state_q == FETCH) && !imem_valid && (tmo_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        fault_d = fault_q;
        case (state_q)
            FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end else if (w_tmo) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end
            end
            DECODE: begin
                if (w_legal) begin
                    state_d = EXECUTE;
                end else begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end
            end
            EXECUTE: begin
                // A taken branch to a non-word-aligned target halts with pc frozen.
                if (w_is_bne && !EQ && w_br_target[1]) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end else begin
                    pc_d    = (w_is_bne && !EQ) ? w_br_target : pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign imem_req  = (state_q == FETCH) && !rst;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign fault     = fault_q;
    assign halted    = (state_q == HALT);

    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign rd       = ir_q[11:7];
    assign ALUsrc   = w_is_addi;
    assign ALUctrl  = (w_is_sub || w_is_bne) ? SUB : ADD;
    assign ImmOp    = (w_opcode == BRANCH) ? w_imm_b : w_imm_i;
    assign RegWrite = (state_q == EXECUTE) && w_writes && (ir_q[11:7] != 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
//============================================================================
// Module      : tb_instr_sequencer
// Description : Randomised scoreboard bench for instr_sequencer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_instr_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        EQ = 1'b0;
    logic        imem_req, RegWrite, ALUsrc, fault, halted;
    logic [31:0] imem_addr, ImmOp, pc;
    logic [2:0]  ALUctrl;
    logic [4:0]  rs1, rs2, rd;

    instr_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .EQ(EQ),
        .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .pc(pc),
        .fault(fault), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        bit          illegal;
        bit          misalign;
        bit          rw;
        bit          alusrc;
        logic [2:0]  aluctrl;
        bit          chk_imm;
        logic [31:0] imm;
        logic [31:0] next_pc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_pc = RST_PC;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference behaviour: classify the word and compute its architectural effect.
    function automatic exp_t model(logic [31:0] cur_pc, logic [31:0] ins, bit eq);
        exp_t        e;
        int          off;
        logic [31:0] tgt;
        bit          addi, add, sub, bne;
        addi = (ins[6:0] == 7'h13) && (ins[14:12] == 3'd0);
        add  = (ins[6:0] == 7'h33) && (ins[14:12] == 3'd0) && (ins[31:25] == 7'h00);
        sub  = (ins[6:0] == 7'h33) && (ins[14:12] == 3'd0) && (ins[31:25] == 7'h20);
        bne  = (ins[6:0] == 7'h63) && (ins[14:12] == 3'd1);
        e.addr     = cur_pc;
        e.instr    = ins;
        e.illegal  = !(addi || add || sub || bne);
        e.rw       = (addi || add || sub) && (ins[11:7] != 5'd0);
        e.alusrc   = addi;
        e.aluctrl  = (sub || bne) ? 3'b001 : 3'b000;
        e.chk_imm  = addi || bne;
        if (bne)
            off = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                  + int'(ins[11:8]) * 2;
        else
            off = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
        e.imm      = 32'(off);
        e.misalign = 1'b0;
        e.next_pc  = cur_pc + 32'd4;
        if (bne && !eq) begin
            tgt = cur_pc + e.imm;
            if (tgt[1]) e.misalign = 1'b1;
            else        e.next_pc  = tgt;
        end
        return e;
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] s1, logic [4:0] d);
        return {imm, s1, 3'b000, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(bit is_sub, logic [4:0] s2, logic [4:0] s1, logic [4:0] d);
        return {(is_sub ? 7'h20 : 7'h00), s2, s1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] off, logic [4:0] s2, logic [4:0] s1);
        return {off[12], off[10:5], s2, s1, 3'b001, off[4:1], off[11], 7'b1100011};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        imem_valid = 1'($urandom_range(0, 1));
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_pc", pc, RST_PC);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_fault", fault, 0);
        chk("rst_halted", halted, 0);
        chk("rst_regwrite", RegWrite, 0);
        sb.delete();
        model_pc   = RST_PC;
        imem_valid = 1'b0;
        rst        = 1'b0;
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input bit eq, input int w);
        exp_t e;
        int   n;
        n = 0;
        while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
        chk("fetch_req_wait", imem_req, 1);
        e = model(model_pc, ins, eq);
        sb.push_back(e);
        imem_valid = 1'b0;
        repeat (w) begin imem_rdata = $urandom; @(posedge clk); #1; end
        imem_valid = 1'b1;
        imem_rdata = ins;
        EQ         = eq;
        @(posedge clk); #1;
        // Noise on the response channel while no request is outstanding.
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        if (e.illegal || e.misalign) begin
            @(posedge clk); #1;
            do_reset();
        end else begin
            model_pc = e.next_pc;
        end
    endtask

    initial begin : monitor
        exp_t cur;
        int   phase = 0;
        bit   chk_pc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase  = 0;
                chk_pc = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (chk_pc) begin
                            chk("next_pc", pc, cur.next_pc);
                            chk("refetch_req", imem_req, 1);
                            chk_pc = 1'b0;
                        end
                        if (imem_req && sb.size() > 0) begin
                            chk("imem_addr", imem_addr, sb[0].addr);
                            chk("fetch_regwrite", RegWrite, 0);
                            if (imem_valid) begin
                                cur   = sb.pop_front();
                                phase = 1;
                            end
                        end
                    end
                    1: begin
                        chk("dec_regwrite", RegWrite, 0);
                        chk("dec_imem_req", imem_req, 0);
                        chk("dec_halted", halted, 0);
                        phase = 2;
                    end
                    2: begin
                        if (cur.illegal) begin
                            chk("ill_halted", halted, 1);
                            chk("ill_fault", fault, 1);
                            chk("ill_imem_req", imem_req, 0);
                            chk("ill_regwrite", RegWrite, 0);
                            chk("ill_pc", pc, cur.addr);
                            phase = 0;
                        end else begin
                            chk("ex_regwrite", RegWrite, cur.rw);
                            chk("ex_rd", rd, cur.instr[11:7]);
                            chk("ex_rs1", rs1, cur.instr[19:15]);
                            chk("ex_rs2", rs2, cur.instr[24:20]);
                            chk("ex_alusrc", ALUsrc, cur.alusrc);
                            chk("ex_aluctrl", ALUctrl, cur.aluctrl);
                            if (cur.chk_imm) chk("ex_immop", ImmOp, cur.imm);
                            chk("ex_imem_req", imem_req, 0);
                            chk("ex_halted", halted, 0);
                            if (cur.misalign) begin
                                phase = 3;
                            end else begin
                                chk_pc = 1'b1;
                                phase  = 0;
                            end
                        end
                    end
                    default: begin
                        chk("mis_halted", halted, 1);
                        chk("mis_fault", fault, 1);
                        chk("mis_imem_req", imem_req, 0);
                        chk("mis_pc", pc, cur.addr);
                        phase = 0;
                    end
                endcase
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] r, ins;
        logic [12:0] boff;
        int          kind;
        do_reset();
        run_instr(NOP_W, 1'b0, 0);
        run_instr(32'h0050_0513, 1'b0, 0);
        run_instr(enc_b(13'h1FF8, 5'd2, 5'd1), 1'b0, 0);
        run_instr(NOP_W, 1'b0, 3);
        run_instr(NOP_W, 1'b1, 0);
        run_instr(enc_b(13'h1FF8, 5'd2, 5'd1), 1'b1, 0);
        run_instr(enc_i(12'd7, 5'd0, 5'd0), 1'b0, 0);
        run_instr(32'hFFFF_FFFF, 1'b0, 0);
`ifdef SEQ_TIMEOUT_EN
        imem_valid = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        chk("tmo_not_yet", halted, 0);
        @(posedge clk); #1;
        chk("tmo_halted", halted, 1);
        chk("tmo_fault", fault, 1);
        chk("tmo_imem_req", imem_req, 0);
        do_reset();
`endif
        repeat (300) begin
            kind = $urandom_range(0, 9);
            r    = $urandom;
            case (kind)
                0, 1: ins = enc_i(r[31:20], r[19:15], (kind == 0 && r[0]) ? 5'd0 : r[11:7]);
                2, 3: ins = enc_r(kind == 3, r[24:20], r[19:15], r[11:7]);
                4, 5, 6: begin
                    boff    = r[12:0];
                    boff[0] = 1'b0;
                    if ($urandom_range(0, 3) != 0) boff[1] = 1'b0;
                    ins = enc_b(boff, r[24:20], r[19:15]);
                end
                7:       ins = r;
                default: ins = enc_r(1'b0, r[24:20], r[19:15], 5'd0);
            endcase
            run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
